// File: rtl/rmii_pkg.sv
// rtl/rmii_pkg.sv - shared dibit codes, CRC-32 constants, decoder state type and helpers
package rmii_pkg;

   localparam logic [1:0]  DIBIT_PRE     = 2'b01;
   localparam logic [1:0]  DIBIT_SFD     = 2'b11;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      DRAIN,
      IDLE,
      PREAMBLE,
      DATA
   } rmii_state_t;

   // Reflected CRC-32 advanced by one dibit; d[0] is the earlier bit on the wire.
   function automatic logic [31:0] crc32_dibit_next(input logic [31:0] crc, input logic [1:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 2; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ CRC32_POLY;
         else             c = c >> 1;
      end
      return c;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, v} + {15'd0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/eth_crc32_dibit.sv
// rtl/eth_crc32_dibit.sv - dibit-serial Ethernet CRC-32 register, shared with the MAC TX path
module eth_crc32_dibit
   import rmii_pkg::*;
(
   input  logic        clock,
   input  logic        aresetn,
   input  logic        clear,
   input  logic        enable,
   input  logic [1:0]  d,
   output logic [31:0] crc
);

   always_ff @(posedge clock) begin
      if (!aresetn || clear) crc <= CRC32_INIT;
      else if (enable)       crc <= crc32_dibit_next(crc, d);
   end

endmodule

// File: rtl/rmii_tx_monitor.sv
// rtl/rmii_tx_monitor.sv - passive RMII TX decoder: SFD lock, byte reassembly, FCS/length checks, counters
module rmii_tx_monitor
   import rmii_pkg::*;
#(
   parameter int MIN_FRAME_BYTES     = 64,
   parameter int MAX_FRAME_BYTES     = 1522,
   parameter int MIN_PREAMBLE_DIBITS = 4
) (
   input  logic        clock,
   input  logic        aresetn,
   input  logic [1:0]  mii_d,
   input  logic        mii_en,
   output logic [7:0]  maxis_tdata,
   output logic        maxis_tvalid,
   output logic        maxis_tuser,
   output logic        maxis_tlast,
   output logic [15:0] frame_count,
   output logic [15:0] error_count
);

   localparam int             PW        = $clog2(MIN_PREAMBLE_DIBITS + 1);
   localparam logic [PW-1:0]  PRE_MIN   = PW'(MIN_PREAMBLE_DIBITS);
   localparam logic [10:0]    MIN_BYTES = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0]    MAX_BYTES = 11'(MAX_FRAME_BYTES);

   logic [1:0]    d_q;
   logic          en_q;
   logic          in_v;
   rmii_state_t   state;
   logic [PW-1:0] pre_cnt;
   logic [PW-1:0] pre_base;
   logic [7:0]    shift_q;
   logic [7:0]    pend_data;
   logic [1:0]    dib_cnt;
   logic [1:0]    pend_age;
   logic [10:0]   byte_cnt;
   logic          pend_v;
   logic          eof_v;
   logic          eof_user;
   logic [31:0]   crc;

   logic in_pre, sfd_take, pre_err, data_dibit, eof_now, byte_done;
   logic tuser_now, slot, frame_inc, eof_err;

   always_comb begin
      in_pre     = (state == IDLE) || (state == PREAMBLE);
      pre_base   = (state == PREAMBLE) ? pre_cnt : '0;
      sfd_take   = in_pre && en_q && (d_q == DIBIT_SFD) && (pre_base >= PRE_MIN);
      pre_err    = (in_pre && en_q && !sfd_take && (d_q != DIBIT_PRE))
                || ((state == PREAMBLE) && !en_q);
      data_dibit = (state == DATA) && en_q;
      eof_now    = (state == DATA) && !en_q;
      byte_done  = data_dibit && (dib_cnt == 2'd3);
      tuser_now  = (dib_cnt != 2'd0) || (crc != CRC32_RESIDUE)
                || (byte_cnt < MIN_BYTES) || (byte_cnt > MAX_BYTES);
      // A pending byte leaves exactly four cycles after it completes, giving a fixed
      // pin-to-beat latency and letting the end of frame mark the last whole byte.
      slot       = pend_v && (pend_age == 2'd3);
      frame_inc  = (slot && (eof_v || eof_now)) || (eof_now && !pend_v);
      eof_err    = (slot && (eof_v ? eof_user : (eof_now && tuser_now))) || (eof_now && !pend_v);
   end

   eth_crc32_dibit u_crc (
      .clock   (clock),
      .aresetn (aresetn),
      .clear   (sfd_take),
      .enable  (data_dibit),
      .d       (d_q),
      .crc     (crc)
   );

   always_ff @(posedge clock) begin
      if (!aresetn) begin
         d_q          <= '0;
         en_q         <= 1'b0;
         in_v         <= 1'b0;
         state        <= DRAIN;
         pre_cnt      <= '0;
         shift_q      <= '0;
         dib_cnt      <= '0;
         byte_cnt     <= '0;
         pend_data    <= '0;
         pend_v       <= 1'b0;
         pend_age     <= '0;
         eof_v        <= 1'b0;
         eof_user     <= 1'b0;
         maxis_tdata  <= '0;
         maxis_tvalid <= 1'b0;
         maxis_tuser  <= 1'b0;
         maxis_tlast  <= 1'b0;
         frame_count  <= '0;
         error_count  <= '0;
      end else begin
         d_q          <= mii_d;
         en_q         <= mii_en;
         in_v         <= 1'b1;
         maxis_tvalid <= 1'b0;
         maxis_tlast  <= 1'b0;
         maxis_tuser  <= 1'b0;

         case (state)
            DRAIN: begin
               // in_v keeps the post-reset zero in en_q from looking like a real gap
               if (in_v && !en_q) state <= IDLE;
            end
            IDLE, PREAMBLE: begin
               if (!en_q) begin
                  state <= IDLE;
               end else if (sfd_take) begin
                  state    <= DATA;
                  shift_q  <= '0;
                  dib_cnt  <= '0;
                  byte_cnt <= '0;
               end else if (d_q == DIBIT_PRE) begin
                  state   <= PREAMBLE;
                  pre_cnt <= (pre_base < PRE_MIN) ? pre_base + PW'(1) : pre_base;
               end else begin
                  state <= DRAIN;
               end
            end
            DATA: begin
               if (en_q) begin
                  shift_q <= {d_q, shift_q[7:2]};
                  dib_cnt <= dib_cnt + 2'd1;
                  if (byte_done && (byte_cnt != 11'h7FF)) byte_cnt <= byte_cnt + 11'd1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= DRAIN;
         endcase

         if (pend_v) pend_age <= pend_age + 2'd1;
         if (slot) begin
            maxis_tvalid <= 1'b1;
            maxis_tdata  <= pend_data;
            pend_v       <= 1'b0;
            eof_v        <= 1'b0;
            if (eof_v || eof_now) begin
               maxis_tlast <= 1'b1;
               maxis_tuser <= eof_v ? eof_user : tuser_now;
            end
         end
         if (byte_done) begin
            pend_data <= {d_q, shift_q[7:2]};
            pend_v    <= 1'b1;
            pend_age  <= '0;
         end
         if (eof_now && pend_v && !slot) begin
            eof_v    <= 1'b1;
            eof_user <= tuser_now;
         end

         frame_count <= sat_add16(frame_count, {1'b0, frame_inc});
         error_count <= sat_add16(error_count, {1'b0, pre_err} + {1'b0, eof_err});
      end
   end

endmodule
